// File: rtl/signed_calc_pkg.sv
// Shared widths, coefficients and operand/result types for the signed shift-add calculator.
package signed_calc_pkg;

  localparam int unsigned IN_W   = 4;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned COEF_X = 7;
  localparam int unsigned COEF_Y = 3;
  localparam int unsigned COEF_Z = 6;

  typedef logic signed [IN_W-1:0]  operand_t;
  typedef logic signed [OUT_W-1:0] result_t;

  typedef struct packed {
    operand_t x;
    operand_t y;
    operand_t z;
  } operands_t;

endpackage

// File: rtl/signed_calc_core.sv
// Combinational F = 7X - 3Y + 6Z built from shifts and adds on sign-extended operands.
module signed_calc_core
  import signed_calc_pkg::*;
(
  input  operand_t x,
  input  operand_t y,
  input  operand_t z,
  output result_t  f_c
);

  result_t xe;
  result_t ye;
  result_t ze;
  result_t x7;
  result_t y3;
  result_t z6;

  // Sign-extend first so every partial product is exact in OUT_W bits.
  assign xe = OUT_W'(x);
  assign ye = OUT_W'(y);
  assign ze = OUT_W'(z);

  assign x7 = (xe <<< 3) - xe;
  assign y3 = (ye <<< 1) + ye;
  assign z6 = (ze <<< 2) + (ze <<< 1);

  assign f_c = x7 - y3 + z6;

endmodule

// File: rtl/signed_calc_v.sv
// Registered wrapper around signed_calc_core with valid tracking.
// Define SIGNED_CALC_IN_REG_EN to add an input register stage (latency 2 edges instead of 1).
module signed_calc_v
  import signed_calc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_au,
  input  logic [IN_W-1:0]  i_bu,
  input  logic [IN_W-1:0]  i_cu,
  output logic [OUT_W-1:0] o_fu,
  output logic             o_valid
);

  operands_t ops;
  logic      ops_valid;
  result_t   f_c;

`ifdef SIGNED_CALC_IN_REG_EN
  // Operand register only loads on valid; the valid bit itself tracks every cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ops       <= '0;
      ops_valid <= 1'b0;
    end else begin
      ops_valid <= i_valid;
      if (i_valid) begin
        ops <= {i_au, i_bu, i_cu};
      end
    end
  end
`else
  always_comb begin
    ops       = {i_au, i_bu, i_cu};
    ops_valid = i_valid;
  end
`endif

  signed_calc_core u_core (
    .x   (ops.x),
    .y   (ops.y),
    .z   (ops.z),
    .f_c (f_c)
  );

  // Result holds between accepted operand sets; valid is a single-cycle strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fu    <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= ops_valid;
      if (ops_valid) begin
        o_fu <= OUT_W'(f_c);
      end
    end
  end

endmodule

// File: tb/tb_signed_calc_v.sv
// Self-checking bench for signed_calc_v: directed vectors, exhaustive sweep, random valid gaps,
// mid-stream asynchronous reset. Latency follows SIGNED_CALC_IN_REG_EN.
module tb_signed_calc_v;

`ifdef SIGNED_CALC_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic [3:0] i_au;
  logic [3:0] i_bu;
  logic [3:0] i_cu;
  logic [7:0] o_fu;
  logic       o_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit v;
    int f;
  } ent_t;

  ent_t q[$];
  int   exp_f = 0;
  bit   exp_v = 1'b0;

  signed_calc_v dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_au    (i_au),
    .i_bu    (i_bu),
    .i_cu    (i_cu),
    .o_fu    (o_fu),
    .o_valid (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int ref_f(input int x, input int y, input int z);
    return 7 * x - 3 * y + 6 * z;
  endfunction

  task automatic check_eq(input string tag, input integer got, input integer exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the model is a delay line of LAT accepted/idle slots.
  task automatic step(input string tag, input bit v, input int a, input int b, input int c);
    ent_t e;
    i_valid = v;
    i_au    = 4'(a);
    i_bu    = 4'(b);
    i_cu    = 4'(c);
    @(posedge i_clk);
    q.push_back('{v, ref_f(a, b, c)});
    if (q.size() >= LAT) begin
      e     = q.pop_front();
      exp_v = e.v;
      if (e.v) exp_f = e.f;
    end else begin
      exp_v = 1'b0;
    end
    @(negedge i_clk);
    check_eq({tag, "_valid"}, integer'(o_valid), integer'(exp_v));
    check_eq({tag, "_fu"}, $signed(o_fu), exp_f);
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i < LAT + 1; i++) step(tag, 1'b0, 0, 0, 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_au    = '0;
    i_bu    = '0;
    i_cu    = '0;
    #2;
    check_eq("reset_fu", $signed(o_fu), 0);
    check_eq("reset_valid", integer'(o_valid), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed vectors with an idle gap so each result is seen and then held.
    step("zero", 1'b1, 0, 0, 0);
    flush("zero_idle");
    step("all_m1", 1'b1, -1, -1, -1);
    flush("all_m1_idle");
    step("m1_0_m1", 1'b1, -1, 0, -1);
    step("one_two_four", 1'b1, 1, 2, 4);
    flush("pair_idle");
    step("min_ext", 1'b1, -8, 7, -8);
    step("max_ext", 1'b1, 7, -8, 7);
    flush("ext_idle");

    // Three back-to-back then low: three pulses, then the last result holds.
    step("b2b0", 1'b1, 3, -2, 5);
    step("b2b1", 1'b1, -4, 6, -7);
    step("b2b2", 1'b1, 2, 1, -3);
    flush("b2b_hold");

    // Exhaustive sweep at full throughput.
    for (int a = -8; a < 8; a++)
      for (int b = -8; b < 8; b++)
        for (int c = -8; c < 8; c++)
          step("sweep", 1'b1, a, b, c);
    flush("sweep_idle");

    // Random valid gaps; operands keep toggling while invalid.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)) - 8,
           int'($urandom_range(0, 15)) - 8,
           int'($urandom_range(0, 15)) - 8);
    end
    flush("rand_idle");

    // Reset mid-stream with results in flight: outputs clear without a clock edge.
    step("pre_rst0", 1'b1, 7, -8, 7);
    step("pre_rst1", 1'b1, 5, -3, 2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_fu", $signed(o_fu), 0);
    check_eq("midrst_valid", integer'(o_valid), 0);
    q.delete();
    exp_f = 0;
    exp_v = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_held_fu", $signed(o_fu), 0);
    i_rst_n = 1'b1;
    flush("post_rst");
    step("post_rst_op", 1'b1, -8, 7, -8);
    flush("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_calc_v.md
SIGNED_CALC_V -- requirements
Module: signed_calc_v

Interface
REQ-001 Parameters: none; all widths and coefficients are fixed constants (see Structure).
REQ-002 i_clk  input  1  single clock; all state rising-edge triggered.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_valid  input  1  high = operands on i_au/i_bu/i_cu are to be sampled this cycle.
REQ-005 i_au  input  4  operand X, 4-bit two's complement, range -8..7.
REQ-006 i_bu  input  4  operand Y, 4-bit two's complement, range -8..7.
REQ-007 i_cu  input  4  operand Z, 4-bit two's complement, range -8..7.
REQ-008 o_fu  output  8  result F, 8-bit two's complement, registered.
REQ-009 o_valid  output  1  high for exactly one cycle per accepted operand set; marks o_fu as new.

Function
REQ-010 F SHALL equal 7*X - 3*Y + 6*Z with X, Y, Z sign-extended before arithmetic.
REQ-011 Result range is -125..+115; 8-bit signed output SHALL represent every result exactly, with no overflow, saturation or wrap logic.
REQ-012 Multipliers SHALL NOT be used: 7X = 8X - X, 3Y = 2Y + Y, 6Z = 4Z + 2Z via shifts and adds.
REQ-013 Intermediate sums SHALL be at least 8 bits signed.
REQ-014 Latency, macro off: i_valid sampled high at edge N -> o_fu and o_valid updated at edge N (visible the cycle after N).
REQ-015 i_valid low at an edge -> o_fu SHALL hold its previous value and o_valid SHALL be 0.
REQ-016 No back-pressure; a new operand set SHALL be accepted every cycle i_valid is high, with full throughput.
REQ-017 Operand values while i_valid is low SHALL have no effect on any output.

Reset
REQ-018 i_rst_n low SHALL immediately (asynchronously) force o_fu = 8'h00, o_valid = 0 and clear every internal register.
REQ-019 Reset deassertion SHALL be synchronized externally; the first operand accepted is on the first rising edge with i_rst_n high.
REQ-020 Reset mid-operation SHALL discard all in-flight results; no o_valid pulse for them after reset.

Configuration
REQ-021 Macro SIGNED_CALC_IN_REG_EN defined: an input register stage captures i_au/i_bu/i_cu/i_valid, and latency becomes 2 edges with throughput unchanged.
REQ-022 Macro SIGNED_CALC_IN_REG_EN undefined: no input register, latency 1 edge as in REQ-014.
REQ-023 Function and reset values SHALL be identical in both builds apart from latency.

Structure
REQ-024 Package signed_calc_pkg SHALL hold: IN_W=4, OUT_W=8, coefficient constants 7/3/6, and operand/result typedefs.
REQ-025 Combinational sub-module signed_calc_core SHALL compute F from X, Y, Z (shift-add only); signed_calc_v SHALL wrap it with the register stage(s) and valid tracking.

Verification
REQ-026 i_au=0000, i_bu=0000, i_cu=0000, i_valid=1 -> o_fu=8'h00 (0), o_valid pulse.
REQ-027 i_au=1111, i_bu=1111, i_cu=1111 (-1,-1,-1) -> o_fu=8'hF6 (-10).
REQ-028 i_au=1111, i_bu=0000, i_cu=1111 -> o_fu=8'hF3 (-13); i_au=0001, i_bu=0010, i_cu=0100 -> o_fu=8'h19 (25).
REQ-029 Extremes: (-8,7,-8) -> 8'h83 (-125); (7,-8,7) -> 8'h73 (115); an exhaustive 4096-combination sweep SHALL match a reference model.
REQ-030 Back-to-back i_valid for 3 cycles then low -> 3 consecutive o_valid pulses with correct latency, and o_fu then holds the last value.
REQ-031 Assert i_rst_n=0 mid-stream -> o_fu=8'h00 and o_valid=0 without a clock edge; run in both macro builds.
